dsp_serial_freezer: RTL



---
 rtl/dsp_serial_freezer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dsp_serial_freezer.sv
// Serial-to-parallel stimulus freezer for a wrapped DSP: shifts wide inputs in over a
// narrow lane, applies and holds them, then captures the response and shifts it back out.
module dsp_serial_freezer #(
  parameter int IN_W     = 256,
  parameter int OUT_W    = 192,
  parameter int LANE_W   = 8,
  parameter int WAIT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LANE_W-1:0] si_data,
  input  logic              si_valid,
  output logic              si_ready,
  output logic [LANE_W-1:0] so_data,
  output logic              so_valid,
  input  logic              so_ready,
  output logic              busy,
  output logic              done,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_SHIFT_IN| collecting input beats into the in-shadow
  // S_APPLY   | one cycle: in-shadow -> dut_in
  // S_WAIT    | settle down-counter running
  // S_CAPTURE | one cycle: dut_out -> out-shadow
  // S_SHIFT_OUT| draining out-shadow one lane per handshake

  localparam int NIN      = (IN_W + LANE_W - 1) / LANE_W;
  localparam int NOUT     = (OUT_W + LANE_W - 1) / LANE_W;
  localparam int NMAX     = (NIN > NOUT) ? NIN : NOUT;
  localparam int CNT_W    = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int WAIT_W   = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int SH_IN_W  = NIN * LANE_W;
  localparam int SH_OUT_W = NOUT * LANE_W;

  localparam logic [CNT_W-1:0]  LAST_IN   = CNT_W'(NIN - 1);
  localparam logic [CNT_W-1:0]  LAST_OUT  = CNT_W'(NOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_APPLY,
    S_WAIT,
    S_CAPTURE,
    S_SHIFT_OUT
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SH_IN_W-1:0]  in_shadow;
  logic [SH_OUT_W-1:0] out_shadow;

  assign so_data = out_shadow[LANE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      in_shadow  <= '0;
      out_shadow <= '0;
      dut_in     <= '0;
      si_ready   <= 1'b0;
      so_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SHIFT_IN;
            beat_cnt <= '0;
            si_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SHIFT_IN: begin
          if (si_valid) begin
            for (int k = 0; k < NIN; k++) begin
              if (beat_cnt == CNT_W'(k)) in_shadow[k*LANE_W +: LANE_W] <= si_data;
            end
            if (beat_cnt == LAST_IN) begin
              state    <= S_APPLY;
              si_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_APPLY: begin
          // bits of the last beat above IN_W never reach the DUT
          dut_in <= in_shadow[IN_W-1:0];
          if (WAIT_CYC > 0) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(1)) state <= S_CAPTURE;
          else                        wait_cnt <= wait_cnt - 1'b1;
        end
        S_CAPTURE: begin
          out_shadow <= SH_OUT_W'(dut_out);
          beat_cnt   <= '0;
          so_valid   <= 1'b1;
          state      <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          if (so_ready) begin
            out_shadow <= out_shadow >> LANE_W;
            if (beat_cnt == LAST_OUT) begin
              state    <= S_IDLE;
              so_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
